perf_counter_bank: RTL and testbench

//  Parametrised bank of NUM_EVENTS hardware event counters, memory-mapped on the
//  CPU data port between the pipeline and L1D. Accesses to the counter window are

---
 rtl/perf_counter_bank.sv | 144 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of memory-mapped hardware event counters sitting on the CPU data port.
// Window accesses get a registered 1-cycle response; everything else passes through to L1D.
module perf_counter_bank #(
    parameter int                    NUM_EVENTS = 10,
    parameter int                    CNT_W      = 32,
    parameter logic [31:0]           BASE_ADDR  = 32'h0000_0000,
    parameter logic [NUM_EVENTS-1:0] EDGE_MASK  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  read_b,
    input  logic                  write_b,
    input  logic [31:0]           address_b,
    input  logic [31:0]           wdata_b,
    output logic [31:0]           rdata_b,
    output logic                  resp_b,
    output logic                  cpu_l1d_read,
    output logic                  cpu_l1d_write,
    output logic [31:0]           cpu_l1d_address,
    output logic [31:0]           cpu_l1d_wdata,
    input  logic [31:0]           cpu_l1d_rdata,
    input  logic                  cpu_l1d_resp,
    output logic                  ovf_any
);

    localparam logic [31:0] WIN_BYTES = 32'(4 * (NUM_EVENTS + 2));
    localparam logic [4:0]  CTRL_IDX  = 5'(NUM_EVENTS);
    localparam logic [4:0]  OVF_IDX   = 5'(NUM_EVENTS + 1);

    // Handshake: a request is accepted in IDLE on the edge where it is a window hit;
    // resp_b is high for exactly the following cycle with the registered read data.
    typedef enum logic {IDLE, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q [NUM_EVENTS];
    logic [CNT_W-1:0]      cnt_d [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_q, ovf_d, ovf_set;
    logic [NUM_EVENTS-1:0] prev_q, inc;
    logic                  freeze_q, sat_q;
    logic [31:0]           rdata_q, rd_word;
    logic [31:0]           offset;
    logic [4:0]            word_idx;
    logic                  hit, accept, aligned, wr_acc;
    logic                  wr_ctrl, wr_ovf, clear_all;

    assign offset   = address_b - BASE_ADDR;
    assign word_idx = offset[6:2];
    assign aligned  = (offset[1:0] == 2'b00);
    assign hit      = (read_b | write_b) && (offset < WIN_BYTES);
    assign accept   = (state_q == IDLE) && hit;
    assign wr_acc   = accept && write_b && aligned;
    assign wr_ctrl  = wr_acc && (word_idx == CTRL_IDX);
    assign wr_ovf   = wr_acc && (word_idx == OVF_IDX);
    assign clear_all = wr_ctrl && wdata_b[1];
    assign inc      = event_i & ~(EDGE_MASK & prev_q);

    always_comb begin
        rd_word = '0;
        if (aligned) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (word_idx == 5'(i)) rd_word = 32'(cnt_q[i]);
            end
            if (word_idx == CTRL_IDX) rd_word = {29'b0, sat_q, 1'b0, freeze_q};
            if (word_idx == OVF_IDX)  rd_word = 32'(ovf_q);
        end
    end

    // Per-counter priority: clear_all, CPU load, freeze, then increment.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_all) begin
                cnt_d[i] = '0;
            end else if (wr_acc && (word_idx == 5'(i))) begin
                cnt_d[i] = wdata_b[CNT_W-1:0];
            end else if (!freeze_q && inc[i]) begin
                if (&cnt_q[i]) begin
                    ovf_set[i] = 1'b1;
                    cnt_d[i]   = sat_q ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        if (clear_all) ovf_d = '0;
        else if (wr_ovf) ovf_d = (ovf_q & ~wdata_b[NUM_EVENTS-1:0]) | ovf_set;
        else ovf_d = ovf_q | ovf_set;
    end

    always_comb begin
        state_d         = state_q;
        rdata_b         = '0;
        resp_b          = 1'b0;
        cpu_l1d_read    = 1'b0;
        cpu_l1d_write   = 1'b0;
        cpu_l1d_address = address_b;
        cpu_l1d_wdata   = wdata_b;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = RESP;
                end else begin
                    cpu_l1d_read  = read_b;
                    cpu_l1d_write = write_b;
                    rdata_b       = cpu_l1d_rdata;
                    resp_b        = cpu_l1d_resp;
                end
            end
            RESP: begin
                resp_b  = 1'b1;
                rdata_b = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
            ovf_q    <= '0;
            prev_q   <= '0;
            freeze_q <= 1'b0;
            sat_q    <= 1'b0;
            rdata_q  <= '0;
            ovf_any  <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= cnt_d[i];
            ovf_q   <= ovf_d;
            prev_q  <= event_i;
            ovf_any <= |ovf_q;
            if (wr_ctrl) begin
                freeze_q <= wdata_b[0];
                sat_q    <= wdata_b[2];
            end
            if (accept) rdata_q <= write_b ? 32'b0 : rd_word;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: 10 events, 8-bit counters, event 0 edge-counted.
module tb_perf_counter_bank;

    localparam logic [31:0] CTRL_A = 32'h28;
    localparam logic [31:0] OVF_A  = 32'h2C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  event_i = '0;
    logic        read_b = 1'b0, write_b = 1'b0;
    logic [31:0] address_b = '0, wdata_b = '0;
    logic [31:0] rdata_b;
    logic        resp_b;
    logic        cpu_l1d_read, cpu_l1d_write;
    logic [31:0] cpu_l1d_address, cpu_l1d_wdata;
    logic [31:0] cpu_l1d_rdata = '0;
    logic        cpu_l1d_resp = 1'b0;
    logic        ovf_any;

    int tests_run = 0;
    int fails = 0;

    perf_counter_bank #(
        .NUM_EVENTS(10), .CNT_W(8), .BASE_ADDR(32'h0), .EDGE_MASK(10'b00_0000_0001)
    ) dut (
        .clk(clk), .reset(reset), .event_i(event_i),
        .read_b(read_b), .write_b(write_b), .address_b(address_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b), .resp_b(resp_b),
        .cpu_l1d_read(cpu_l1d_read), .cpu_l1d_write(cpu_l1d_write),
        .cpu_l1d_address(cpu_l1d_address), .cpu_l1d_wdata(cpu_l1d_wdata),
        .cpu_l1d_rdata(cpu_l1d_rdata), .cpu_l1d_resp(cpu_l1d_resp),
        .ovf_any(ovf_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
        address_b = addr;
        read_b    = 1'b1;
        #1;
        check("rd_resp_accept", {31'b0, resp_b}, 32'd0);
        check("rd_no_l1d", {31'b0, cpu_l1d_read}, 32'd0);
        @(posedge clk); #1;
        read_b = 1'b0;
        check("rd_resp_next", {31'b0, resp_b}, 32'd1);
        data = rdata_b;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic [9:0] ev);
        address_b = addr;
        wdata_b   = data;
        write_b   = 1'b1;
        event_i   = ev;
        @(posedge clk); #1;
        write_b = 1'b0;
        event_i = '0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_events(input int bit_idx, input int cycles);
        event_i[bit_idx] = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        event_i[bit_idx] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp", {31'b0, resp_b}, 32'd0);
        check("rst_rdata", rdata_b, 32'd0);
        check("rst_ovf_any", {31'b0, ovf_any}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Level counting on event 3
        pulse_events(3, 5);
        read_check("level_cnt3", 32'h0C, 32'd5);

        // Edge counting on event 0: two rising edges
        pulse_events(0, 6);
        @(posedge clk); #1;
        pulse_events(0, 2);
        read_check("edge_cnt0", 32'h00, 32'd2);

        // Wrap mode overflow
        cpu_write(CTRL_A, 32'd0, '0);
        cpu_write(32'h04, 32'hFE, '0);
        pulse_events(1, 3);
        read_check("wrap_cnt1", 32'h04, 32'h01);
        read_check("wrap_ovf", OVF_A, 32'h2);
        check("wrap_ovf_any", {31'b0, ovf_any}, 32'd1);
        cpu_write(OVF_A, 32'h2, '0);
        read_check("ovf_cleared", OVF_A, 32'h0);
        check("ovf_any_cleared", {31'b0, ovf_any}, 32'd0);

        // Saturate mode overflow
        cpu_write(CTRL_A, 32'h4, '0);
        cpu_write(32'h04, 32'hFE, '0);
        pulse_events(1, 3);
        read_check("sat_cnt1", 32'h04, 32'hFF);
        read_check("sat_ovf", OVF_A, 32'h2);
        read_check("ctrl_sat", CTRL_A, 32'h4);

        // Freeze, load beats event, clear_all beats event
        cpu_write(CTRL_A, 32'h5, '0);
        pulse_events(2, 4);
        read_check("frozen_cnt2", 32'h08, 32'd0);
        cpu_write(32'h08, 32'd7, 10'b00_0000_0100);
        read_check("load_frozen", 32'h08, 32'd7);
        cpu_write(CTRL_A, 32'h2, 10'b00_0000_0100);
        read_check("clear_cnt2", 32'h08, 32'd0);
        read_check("clear_cnt1", 32'h04, 32'd0);
        read_check("clear_ovf", OVF_A, 32'd0);
        read_check("ctrl_after_clr", CTRL_A, 32'd0);
        cpu_write(32'h08, 32'h11, 10'b00_0000_0100);
        read_check("load_beats_inc", 32'h08, 32'h11);
        pulse_events(2, 1);
        read_check("count_resumes", 32'h08, 32'h12);

        // Read and write together is a write with zero response data
        address_b = 32'h0; wdata_b = 32'h33; read_b = 1'b1; write_b = 1'b1;
        @(posedge clk); #1;
        read_b = 1'b0; write_b = 1'b0;
        check("rw_resp", {31'b0, resp_b}, 32'd1);
        check("rw_rdata", rdata_b, 32'd0);
        @(posedge clk); #1;
        read_check("rw_loaded", 32'h00, 32'h33);

        // Misaligned accesses inside the window
        cpu_write(32'h04, 32'h5A, '0);
        read_check("mis_rd", 32'h05, 32'd0);
        cpu_write(32'h06, 32'h44, '0);
        read_check("mis_wr_ignored", 32'h04, 32'h5A);

        // Passthrough outside the window
        address_b = 32'h100; read_b = 1'b1;
        cpu_l1d_rdata = 32'hDEAD_BEEF; cpu_l1d_resp = 1'b1;
        #1;
        check("pt_read", {31'b0, cpu_l1d_read}, 32'd1);
        check("pt_addr", cpu_l1d_address, 32'h100);
        check("pt_rdata", rdata_b, 32'hDEAD_BEEF);
        check("pt_resp", {31'b0, resp_b}, 32'd1);
        read_b = 1'b0; write_b = 1'b1; address_b = 32'h104; wdata_b = 32'h55;
        #1;
        check("pt_write", {31'b0, cpu_l1d_write}, 32'd1);
        check("pt_wdata", cpu_l1d_wdata, 32'h55);
        @(posedge clk); #1;
        write_b = 1'b0; cpu_l1d_resp = 1'b0; cpu_l1d_rdata = '0;
        read_check("pt_no_change", 32'h00, 32'h33);

        // Overflow on counter 3, then async reset while in RESP
        cpu_write(32'h0C, 32'hFF, '0);
        pulse_events(3, 1);
        @(posedge clk); #1;
        check("ovf3_any", {31'b0, ovf_any}, 32'd1);
        pulse_events(3, 2);
        address_b = 32'h0C; read_b = 1'b1;
        @(posedge clk); #1;
        read_b = 1'b0;
        check("pre_rst_resp", {31'b0, resp_b}, 32'd1);
        check("pre_rst_data", rdata_b, 32'd2);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_resp", {31'b0, resp_b}, 32'd0);
        check("mid_rst_ovf_any", {31'b0, ovf_any}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        read_check("rst_cnt3", 32'h0C, 32'd0);
        read_check("rst_cnt0", 32'h00, 32'd0);
        read_check("rst_ovf", OVF_A, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
